// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the async-SRAM access controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_ACCESS,
    ST_RD_DONE,
    ST_TURN
  } state_e;

  // Bit positions inside req_be = {ub, lb}
  localparam int unsigned LANE_LB = 0;
  localparam int unsigned LANE_UB = 1;

  // Legal range of the strobe timing parameters (3-bit down-counter)
  localparam int unsigned WR_PULSE_MIN = 1;
  localparam int unsigned WR_PULSE_MAX = 7;
  localparam int unsigned RD_WAIT_MIN  = 1;
  localparam int unsigned RD_WAIT_MAX  = 7;

  // Forces an out-of-range timing parameter into the supported range
  function automatic int unsigned clamp_cycles(input int unsigned v,
                                               input int unsigned lo,
                                               input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Async-SRAM access controller: one word read/write at a time over
// valid/ready, fixed-cycle CE/WE/OE/LB/UB sequencing, registered outputs.
// Optional macro SRAM_CTRL_TURNAROUND_EN inserts one bus-turnaround cycle
// before a write that directly follows a read.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W          = 19,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WR_PULSE_CYCLES = 1,
  parameter int unsigned RD_WAIT_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  localparam int unsigned WR_P = clamp_cycles(WR_PULSE_CYCLES, WR_PULSE_MIN, WR_PULSE_MAX);
  localparam int unsigned RD_W = clamp_cycles(RD_WAIT_CYCLES, RD_WAIT_MIN, RD_WAIT_MAX);
  localparam logic [2:0]  WR_LOAD = 3'(WR_P - 1);
  localparam logic [2:0]  RD_LOAD = 3'(RD_W - 1);

  state_e              state_q;
  logic [2:0]          cnt_q;
  logic [1:0]          be_q;
  logic                req_ready_q, rsp_valid_q, busy_q;
  logic [DATA_W-1:0]   rsp_rdata_q, dout_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                dq_oe_q, ce_n_q, we_n_q, oe_n_q, lb_n_q, ub_n_q;
`ifdef SRAM_CTRL_TURNAROUND_EN
  logic                last_rd_q;
`endif

  // Access sequencer: state, timing counter and every registered pin
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
      last_rd_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            be_q        <= req_be;
            addr_q      <= req_addr;
            ce_n_q      <= 1'b0;
            lb_n_q      <= ~req_be[LANE_LB];
            ub_n_q      <= ~req_be[LANE_UB];
            if (req_we) begin
              cnt_q   <= WR_LOAD;
              dout_q  <= req_wdata;
              dq_oe_q <= 1'b1;
              state_q <= ST_WR_SETUP;
`ifdef SRAM_CTRL_TURNAROUND_EN
              // Later assignments override the setup values: park the bus
              // for one cycle so the SRAM releases DQ before we drive it.
              if (last_rd_q) begin
                state_q <= ST_TURN;
                ce_n_q  <= 1'b1;
                dq_oe_q <= 1'b0;
                lb_n_q  <= 1'b1;
                ub_n_q  <= 1'b1;
              end
              last_rd_q <= 1'b0;
`endif
            end else begin
              cnt_q   <= RD_LOAD;
              oe_n_q  <= 1'b0;
              state_q <= ST_RD_ACCESS;
`ifdef SRAM_CTRL_TURNAROUND_EN
              last_rd_q <= 1'b1;
`endif
            end
          end
        end
`ifdef SRAM_CTRL_TURNAROUND_EN
        ST_TURN: begin
          ce_n_q  <= 1'b0;
          dq_oe_q <= 1'b1;
          lb_n_q  <= ~be_q[LANE_LB];
          ub_n_q  <= ~be_q[LANE_UB];
          state_q <= ST_WR_SETUP;
        end
`endif
        ST_WR_SETUP: begin
          we_n_q  <= 1'b0;
          state_q <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (cnt_q == 3'd0) begin
            we_n_q  <= 1'b1;
            state_q <= ST_WR_HOLD;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_WR_HOLD: begin
          ce_n_q      <= 1'b1;
          dq_oe_q     <= 1'b0;
          lb_n_q      <= 1'b1;
          ub_n_q      <= 1'b1;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        ST_RD_ACCESS: begin
          if (cnt_q == 3'd0) begin
            rsp_rdata_q <= sram_din & {{(DATA_W/2){be_q[LANE_UB]}},
                                       {(DATA_W/2){be_q[LANE_LB]}}};
            rsp_valid_q <= 1'b1;
            oe_n_q      <= 1'b1;
            state_q     <= ST_RD_DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RD_DONE: begin
          rsp_valid_q <= 1'b0;
          ce_n_q      <= 1'b1;
          lb_n_q      <= 1'b1;
          ub_n_q      <= 1'b1;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign busy       = busy_q;
  assign sram_addr  = addr_q;
  assign sram_dout  = dout_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (default timing, and 3-cycle pulse/wait)
// checked every cycle against a transaction-level schedule model.
module tb_sram_ctrl;

  localparam int AW = 19;
  localparam int DW = 16;
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic          resetn    [2];
  logic          req_valid [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic [1:0]    req_be    [2];
  logic          req_ready [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_rdata [2];
  logic          busy      [2];
  logic [AW-1:0] sram_addr [2];
  logic [DW-1:0] sram_dout [2];
  logic [DW-1:0] sram_din  [2];
  logic          sram_dq_oe[2];
  logic          sram_ce_n [2];
  logic          sram_we_n [2];
  logic          sram_oe_n [2];
  logic          sram_lb_n [2];
  logic          sram_ub_n [2];

  sram_ctrl dut0 (
    .clk(clk), .resetn(resetn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .sram_addr(sram_addr[0]), .sram_dout(sram_dout[0]), .sram_din(sram_din[0]),
    .sram_dq_oe(sram_dq_oe[0]), .sram_ce_n(sram_ce_n[0]), .sram_we_n(sram_we_n[0]),
    .sram_oe_n(sram_oe_n[0]), .sram_lb_n(sram_lb_n[0]), .sram_ub_n(sram_ub_n[0])
  );

  sram_ctrl #(.WR_PULSE_CYCLES(3), .RD_WAIT_CYCLES(3)) dut1 (
    .clk(clk), .resetn(resetn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .sram_addr(sram_addr[1]), .sram_dout(sram_dout[1]), .sram_din(sram_din[1]),
    .sram_dq_oe(sram_dq_oe[1]), .sram_ce_n(sram_ce_n[1]), .sram_we_n(sram_we_n[1]),
    .sram_oe_n(sram_oe_n[1]), .sram_lb_n(sram_lb_n[1]), .sram_ub_n(sram_ub_n[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, i, act, exp, $time);
  endtask

  function automatic int unsigned pulse_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic int unsigned wait_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic logic [DW-1:0] lmask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction
  function automatic int unsigned mkey(input int i, input logic [AW-1:0] a);
    return (32'(i) << 20) | 32'(a);
  endfunction

  // Reference memory (updated on accepted writes) and pin-level SRAM model;
  // unwritten locations read as 0xFFFF.
  logic [DW-1:0] ref_mem [int unsigned];
  logic [DW-1:0] pin_mem [int unsigned];

  // Inputs as seen by the DUT at each rising edge
  logic          cap_rst [2], cap_valid [2], cap_we [2];
  logic [AW-1:0] cap_addr [2];
  logic [DW-1:0] cap_wdata [2];
  logic [1:0]    cap_be [2];
  logic          started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      cap_rst[i]   <= resetn[i];
      cap_valid[i] <= req_valid[i];
      cap_we[i]    <= req_we[i];
      cap_addr[i]  <= req_addr[i];
      cap_wdata[i] <= req_wdata[i];
      cap_be[i]    <= req_be[i];
    end
  end

  // Model: a transaction is a schedule indexed by edges since acceptance
  bit            m_act [2], m_we [2], m_turn [2], m_ready [2], m_last_rd [2];
  int unsigned   m_c [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_dout [2], m_rdata [2];
  logic [1:0]    m_be [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_ready[i] = 0; m_last_rd[i] = 0; m_c[i] = 0;
      m_we[i] = 0; m_turn[i] = 0; m_addr[i] = '0; m_dout[i] = '0; m_rdata[i] = '0; m_be[i] = '0;
      sram_din[i] = 16'hDEAD;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (started) begin
          // advance the model by the edge just taken
          if (!cap_rst[i]) begin
            m_act[i] = 0; m_ready[i] = 0; m_last_rd[i] = 0; m_c[i] = 0;
            m_addr[i] = '0; m_dout[i] = '0;
          end else if (!m_act[i]) begin
            if (m_ready[i] && cap_valid[i]) begin
              m_act[i] = 1; m_c[i] = 0; m_ready[i] = 0;
              m_we[i] = cap_we[i]; m_be[i] = cap_be[i]; m_addr[i] = cap_addr[i];
              m_turn[i] = TURN_EN && cap_we[i] && m_last_rd[i];
              m_last_rd[i] = !cap_we[i];
              if (cap_we[i]) begin
                logic [DW-1:0] old, mk;
                int unsigned k;
                k = mkey(i, cap_addr[i]);
                old = ref_mem.exists(k) ? ref_mem[k] : 16'hFFFF;
                mk = lmask(cap_be[i]);
                ref_mem[k] = (old & ~mk) | (cap_wdata[i] & mk);
                m_dout[i] = cap_wdata[i];
              end else begin
                int unsigned k;
                k = mkey(i, cap_addr[i]);
                m_rdata[i] = (ref_mem.exists(k) ? ref_mem[k] : 16'hFFFF) & lmask(cap_be[i]);
              end
            end else begin
              m_ready[i] = 1;
            end
          end else begin
            int unsigned dur;
            m_c[i]++;
            dur = m_we[i] ? pulse_of(i) + 2 + (m_turn[i] ? 1 : 0) : wait_of(i) + 1;
            if (m_c[i] == dur) begin
              m_act[i] = 0; m_ready[i] = 1;
            end
          end

          // compare every DUT output against the schedule
          begin
            logic e_ce, e_we, e_oe, e_lb, e_ub, e_dq, e_busy, e_rv;
            bit   chk_ad;
            e_ce = 1; e_we = 1; e_oe = 1; e_lb = 1; e_ub = 1; e_dq = 0;
            e_busy = 0; e_rv = 0; chk_ad = 1;
            if (m_act[i]) begin
              e_busy = 1;
              if (m_we[i]) begin
                if (m_turn[i] && m_c[i] == 0) begin
                  chk_ad = 0;
                end else begin
                  int s;
                  s = int'(m_c[i]) - (m_turn[i] ? 1 : 0);
                  e_ce = 0; e_dq = 1; e_lb = ~m_be[i][0]; e_ub = ~m_be[i][1];
                  e_we = (s >= 1 && s <= int'(pulse_of(i))) ? 1'b0 : 1'b1;
                end
              end else begin
                e_ce = 0; e_lb = ~m_be[i][0]; e_ub = ~m_be[i][1];
                e_oe = (m_c[i] < wait_of(i)) ? 1'b0 : 1'b1;
                e_rv = (m_c[i] == wait_of(i));
              end
            end
            chk("ce_n", i, sram_ce_n[i], e_ce);
            chk("we_n", i, sram_we_n[i], e_we);
            chk("oe_n", i, sram_oe_n[i], e_oe);
            chk("lb_n", i, sram_lb_n[i], e_lb);
            chk("ub_n", i, sram_ub_n[i], e_ub);
            chk("dq_oe", i, sram_dq_oe[i], e_dq);
            chk("busy", i, busy[i], e_busy);
            chk("req_ready", i, req_ready[i], m_ready[i]);
            chk("rsp_valid", i, rsp_valid[i], e_rv);
            if (chk_ad) begin
              chk("sram_addr", i, sram_addr[i], m_addr[i]);
              chk("sram_dout", i, sram_dout[i], m_dout[i]);
            end
            if (e_rv) chk("rsp_rdata", i, rsp_rdata[i], m_rdata[i]);
            if (!cap_rst[i]) chk("rsp_rdata_rst", i, rsp_rdata[i], 0);
            chk("inv_dq_oe_oe", i, sram_dq_oe[i] && !sram_oe_n[i], 0);
            chk("inv_we_dq", i, !sram_we_n[i] && !sram_dq_oe[i], 0);
          end
        end

        // SRAM pins: write enabled lanes while WE_n low, present data while OE_n low
        if (sram_ce_n[i] === 1'b0 && sram_we_n[i] === 1'b0) begin
          logic [DW-1:0] old, mk;
          int unsigned k;
          k = mkey(i, sram_addr[i]);
          old = pin_mem.exists(k) ? pin_mem[k] : 16'hFFFF;
          mk = lmask({~sram_ub_n[i], ~sram_lb_n[i]});
          pin_mem[k] = (old & ~mk) | (sram_dout[i] & mk);
        end
        if (sram_ce_n[i] === 1'b0 && sram_oe_n[i] === 1'b0) begin
          int unsigned k;
          k = mkey(i, sram_addr[i]);
          sram_din[i] = pin_mem.exists(k) ? pin_mem[k] : 16'hFFFF;
        end else begin
          sram_din[i] = 16'hDEAD;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Present a request; returns one cycle after the accepting edge
  task automatic send(input int i, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [1:0] be, input bit keep);
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d; req_be[i] = be;
    for (int k = 0; k < 40; k++) begin
      if (m_ready[i]) begin
        step(1);
        if (!keep) req_valid[i] = 1'b0;
        return;
      end
      step(1);
    end
    n_chk++;
    $display("FAIL accept_timeout[%0d] got=not_accepted want=accepted t=%0t", i, $time);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input string nm, input logic [DW-1:0] exp);
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid[i] === 1'b1) begin
        chk(nm, i, rsp_rdata[i], exp);
        return;
      end
      step(1);
    end
    n_chk++;
    $display("FAIL %s_timeout[%0d] got=no_rsp_valid want=rsp_valid t=%0t", nm, i, $time);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      resetn[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
    end
    step(3);
    chk("lit_reset_ce_n", 0, sram_ce_n[0], 1);
    chk("lit_reset_ready", 0, req_ready[0], 0);
    chk("lit_reset_addr", 1, sram_addr[1], 0);
    resetn[0] = 1'b1; resetn[1] = 1'b1;
    step(1);
    chk("lit_ready_after_reset", 0, req_ready[0], 1);

    // full-word write and read-back
    send(0, 1, 19'h12345, 16'hBEEF, 2'b11, 0);
    chk("lit_wr_addr", 0, sram_addr[0], 19'h12345);
    step(1);
    send(0, 0, 19'h12345, 16'h0000, 2'b11, 0);
    wait_rsp(0, "lit_rd_beef", 16'hBEEF);

    // byte-lane write over 0xFFFF, masked reads
    send(0, 1, 19'h00100, 16'hA55A, 2'b01, 0);
    chk("lit_lb_write_ub_n", 0, sram_ub_n[0], 1);
    send(0, 0, 19'h00100, 16'h0000, 2'b11, 0);
    wait_rsp(0, "lit_rd_ff5a", 16'hFF5A);
    send(0, 0, 19'h00100, 16'h0000, 2'b10, 0);
    wait_rsp(0, "lit_rd_ff00", 16'hFF00);

    // valid held high across alternating writes/reads
    send(0, 1, 19'h00200, 16'h1111, 2'b11, 1);
    send(0, 0, 19'h00200, 16'h0000, 2'b11, 1);
    send(0, 1, 19'h00201, 16'h2222, 2'b11, 1);
    send(0, 0, 19'h00201, 16'h0000, 2'b11, 0);
    wait_rsp(0, "lit_b2b_rd", 16'h2222);
    step(3);

    // be=0 no-op write and zero read
    send(0, 1, 19'h00200, 16'h0000, 2'b00, 0);
    send(0, 0, 19'h00200, 16'h0000, 2'b00, 0);
    wait_rsp(0, "lit_rd_be0", 16'h0000);
    send(0, 0, 19'h00200, 16'h0000, 2'b11, 0);
    wait_rsp(0, "lit_rd_after_be0", 16'h1111);

    // long timing instance at the top address
    send(1, 1, 19'h7FFFF, 16'h1234, 2'b11, 0);
    send(1, 0, 19'h7FFFF, 16'h0000, 2'b11, 0);
    wait_rsp(1, "lit_rd_top", 16'h1234);
    chk("lit_rd_top_addr", 1, sram_addr[1], 19'h7FFFF);

    // reset during the write pulse
    step(2);
    send(1, 1, 19'h00055, 16'hCAFE, 2'b11, 0);
    step(1);
    chk("lit_pulse_we_n", 1, sram_we_n[1], 0);
    resetn[1] = 1'b0;
    step(1);
    chk("lit_rst_we_n", 1, sram_we_n[1], 1);
    chk("lit_rst_ce_n", 1, sram_ce_n[1], 1);
    chk("lit_rst_ready", 1, req_ready[1], 0);
    resetn[1] = 1'b1;
    step(1);
    chk("lit_rst_ready_back", 1, req_ready[1], 1);
    send(1, 0, 19'h7FFFF, 16'h0000, 2'b01, 0);
    wait_rsp(1, "lit_rd_after_rst", 16'h0034);
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Async-SRAM access controller that sits directly between a requester (memory tester, pattern loader) and the board's 512Kx16 SRAM pins. Accepts one word-wide read or write request at a time over a valid/ready handshake, sequences CE/WE/OE/LB/UB with fixed cycle timing at 25 MHz, and returns read data with a one-cycle rsp_valid pulse. Drives a separate data-bus output-enable for the bidirectional pad cells.

Parameters:
ADDR_W, 19, SRAM word-address width
DATA_W, 16, SRAM data width (two byte lanes)
WR_PULSE_CYCLES, 1, cycles WE_n held low (1..7)
RD_WAIT_CYCLES, 1, cycles between address/OE_n assertion and data sample (1..7)

Ports:
clk  in  1  system clock (25 MHz)
resetn  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller idle, request accepted on valid&&ready edge
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  2  byte enables {ub,lb}
rsp_valid  out  1  one-cycle read-data strobe
rsp_rdata  out  DATA_W  read data, disabled lanes forced to 0
busy  out  1  access in progress (not IDLE)
sram_addr  out  ADDR_W  SRAM address
sram_dout  out  DATA_W  data to pads
sram_din  in  DATA_W  data from pads
sram_dq_oe  out  1  1=FPGA drives data bus
sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes

Behaviour:
- All outputs registered. Reset: ce_n/we_n/oe_n/lb_n/ub_n=1, dq_oe=0, addr=0, dout=0, rsp_valid=0, rsp_rdata=0, busy=0, req_ready=0; req_ready=1 from the first cycle after resetn high.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, RD_DONE, TURN (optional).
- req_ready=1 only in IDLE; request latched (addr, wdata, be, we) on accepting edge E0; req_* ignored otherwise.
- Write: after E0 -> WR_SETUP 1 cycle: ce_n=0, addr/dout/lb_n/ub_n=~be driven, dq_oe=1, we_n=1, oe_n=1. WR_PULSE WR_PULSE_CYCLES cycles: we_n=0. WR_HOLD 1 cycle: we_n=1, addr/dout/dq_oe held. -> IDLE. Total 2+WR_PULSE_CYCLES busy cycles; addr/data stable across entire WE_n low window.
- Read: after E0 -> RD_ACCESS for RD_WAIT_CYCLES: ce_n=0, oe_n=0, dq_oe=0, lb_n/ub_n=~be. On last RD_ACCESS edge: rsp_rdata <= sram_din masked by be, rsp_valid<=1. RD_DONE 1 cycle: oe_n=1, rsp_valid=1. -> IDLE. rsp_valid high exactly one cycle, RD_WAIT_CYCLES edges after E0.
- IDLE: ce_n=1, lb_n/ub_n=1, we_n=1, oe_n=1, dq_oe=0; addr/dout hold last value.
- req_be=0: full timing executed, both lane strobes stay high (no-op), read returns 0.
- Back-to-back: new request accepted in the cycle IDLE is re-entered; max throughput one write per 3+WR_PULSE_CYCLES cycles.
- Reset mid-operation: on the first edge with resetn=0 all strobes deasserted (we_n=1 immediately), pending read response dropped, state IDLE.
- Invariant: dq_oe=1 and oe_n=0 never simultaneously; we_n=0 implies dq_oe=1.

Optional Feature:
SRAM_CTRL_TURNAROUND_EN: defined -> write accepted immediately after a read (previous access was read) passes through TURN 1 cycle (ce_n=1, oe_n=1, dq_oe=0) before WR_SETUP; write busy time +1. Undefined -> write enters WR_SETUP directly; no TURN state synthesized.

Decomposition:
- sram_ctrl_pkg: state enum, byte-lane indices, min/max timing constants for WR_PULSE_CYCLES and RD_WAIT_CYCLES range checks.
- No sub-module; single 3-bit down-counter for pulse/wait inline.

Test Plan:
- Write addr 0x12345 data 0xBEEF be=11 -> we_n low exactly 1 cycle, addr=0x12345/dout=0xBEEF/dq_oe=1 stable from WR_SETUP through WR_HOLD, busy 3 cycles.
- Read back 0x12345 with SRAM model -> rsp_valid single pulse 1 edge after accept, rsp_rdata=0xBEEF, dq_oe=0 throughout.
- Write be=01 data 0xA55A then read be=11 over model preset 0xFFFF -> lb_n=0/ub_n=1 in write, read returns 0xFF5A; read with be=10 returns 0xFF00.
- req_valid held high for 4 alternating write/read requests -> req_ready only in IDLE, no request lost, no cycle with dq_oe=1&&oe_n=0; with SRAM_CTRL_TURNAROUND_EN, one extra ce_n=1 cycle before each write following a read.
- resetn low during WR_PULSE (WR_PULSE_CYCLES=3) -> we_n=1 next edge, all strobes high, rsp_valid=0, req_ready returns 1 cycle after release.
- RD_WAIT_CYCLES=3 read of 0x7FFFF -> rsp_valid 3 edges after accept, sram_addr=0x7FFFF, value matches model.
